mouse_motion_tracker: RTL and testbench

Parametrised PS/2 mouse motion tracker that sits between the PS/2 byte receiver and the drawing/GPIO logic. It frames raw mouse bytes into 3-byte packets and accumulates signed deltas into a clamped screen position. It then quantises that position into bins with hysteresis and drives button levels plus a held motion/idle indicator pair for GPIO. It generalises the fixed 640x480 tracker with configurable screen size, bin size, hysteresis, hold time and resync timeout, and adds framing error detection.

---
 rtl/mouse_motion_tracker.sv | 158 +++++++++++++++
 tb/tb_mouse_motion_tracker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_motion_tracker.sv
// PS/2 mouse motion tracker: frames 3-byte packets into a clamped position, hysteretic bins,
// button levels and a held motion/idle pair. Define MOUSE_TIMEOUT_EN to add an inter-byte gap timeout.
module mouse_motion_tracker #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int COORD_W        = 11,
    parameter int BIN            = 100,
    parameter int HYSTERESIS     = 30,
    parameter int HOLD_CYCLES    = 1000000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [COORD_W-1:0] bin_x,
    output logic [COORD_W-1:0] bin_y,
    output logic               btn_left,
    output logic               btn_right,
    output logic               btn_middle,
    output logic               pkt_valid,
    output logic               pkt_err,
    output logic               motion,
    output logic               idle
);
    // state | meaning
    // B0    | waiting for byte0 (bit3 set); any other byte is a framing error
    // B1    | waiting for the dx byte
    // B2    | waiting for the dy byte; packet accepted when it arrives
    typedef enum logic [1:0] {B0, B1, B2} state_t;

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0]  X_MAX  = SW'(WIDTH - 1);
    localparam logic signed [SW-1:0]  Y_MAX  = SW'(HEIGHT - 1);
    localparam logic [COORD_W-1:0]    POS_X0 = COORD_W'(WIDTH / 2);
    localparam logic [COORD_W-1:0]    POS_Y0 = COORD_W'(HEIGHT / 2);
    localparam logic [COORD_W-1:0]    BIN_X0 = COORD_W'((WIDTH / 2) / BIN);
    localparam logic [COORD_W-1:0]    BIN_Y0 = COORD_W'((HEIGHT / 2) / BIN);

    state_t                state, state_nxt;
    logic [7:0]            byte0, byte1;
    logic                  accept, frame_err, timeout;
    logic [8:0]            dx9, dy9;
    logic signed [SW-1:0]  dx_ext, dy_ext, sum_x, sum_y;
    logic [COORD_W-1:0]    pos_x_nxt, pos_y_nxt;
    logic                  bin_x_chg, bin_y_chg;
    logic [31:0]           hold_cnt;
    logic                  unused_b0;

    assign unused_b0 = byte0[3];

    function automatic logic bin_moves(input logic [COORD_W-1:0] pos, input logic [COORD_W-1:0] bin);
        logic [31:0] p, b;
        p = 32'(pos);
        b = 32'(bin);
        return (p >= (b + 32'd1) * 32'(BIN) + 32'(HYSTERESIS)) ||
               (p + 32'(HYSTERESIS) < b * 32'(BIN));
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frame_err = 1'b0;
        if (timeout) begin
            state_nxt = B0;
            frame_err = 1'b1;
        end else if (rx_valid) begin
            case (state)
                B0: if (rx_data[3]) state_nxt = B1;
                    else            frame_err = 1'b1;
                B1: state_nxt = B2;
                B2: begin
                    state_nxt = B0;
                    accept    = 1'b1;
                end
                default: state_nxt = B0;
            endcase
        end
    end

    // dy comes straight from the third byte so the packet lands on the edge that receives it
    always_comb begin
        dx9    = {byte0[4], byte1};
        dy9    = {byte0[5], rx_data};
        dx_ext = byte0[6] ? '0 : SW'($signed(dx9));
        dy_ext = byte0[7] ? '0 : SW'($signed(dy9));
        sum_x  = $signed({2'b00, pos_x}) + dx_ext;
        sum_y  = $signed({2'b00, pos_y}) - dy_ext;
        if (sum_x < 0)          pos_x_nxt = '0;
        else if (sum_x > X_MAX) pos_x_nxt = X_MAX[COORD_W-1:0];
        else                    pos_x_nxt = sum_x[COORD_W-1:0];
        if (sum_y < 0)          pos_y_nxt = '0;
        else if (sum_y > Y_MAX) pos_y_nxt = Y_MAX[COORD_W-1:0];
        else                    pos_y_nxt = sum_y[COORD_W-1:0];
        bin_x_chg = bin_moves(pos_x, bin_x);
        bin_y_chg = bin_moves(pos_y, bin_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= B0;
            byte0      <= '0;
            byte1      <= '0;
            pos_x      <= POS_X0;
            pos_y      <= POS_Y0;
            bin_x      <= BIN_X0;
            bin_y      <= BIN_Y0;
            btn_left   <= 1'b0;
            btn_right  <= 1'b0;
            btn_middle <= 1'b0;
            pkt_valid  <= 1'b0;
            pkt_err    <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            pkt_valid <= accept;
            pkt_err   <= frame_err;
            if (rx_valid && state == B0) byte0 <= rx_data;
            if (rx_valid && state == B1) byte1 <= rx_data;
            if (accept) begin
                btn_left   <= byte0[0];
                btn_right  <= byte0[1];
                btn_middle <= byte0[2];
                if (start) begin
                    pos_x <= pos_x_nxt;
                    pos_y <= pos_y_nxt;
                end
            end
            if (bin_x_chg) bin_x <= COORD_W'(32'(pos_x) / 32'(BIN));
            if (bin_y_chg) bin_y <= COORD_W'(32'(pos_y) / 32'(BIN));
            if (bin_x_chg || bin_y_chg) hold_cnt <= 32'(HOLD_CYCLES);
            else if (hold_cnt != 32'd0) hold_cnt <= hold_cnt - 32'd1;
        end
    end

`ifdef MOUSE_TIMEOUT_EN
    logic [31:0] gap_cnt;

    // Down-counter reloaded by every byte; terminal count mid-packet abandons the packet
    assign timeout = (state != B0) && !rx_valid && (gap_cnt == 32'd0);

    always_ff @(posedge clk) begin
        if (reset || rx_valid || state == B0 || timeout) gap_cnt <= 32'(TIMEOUT_CYCLES - 1);
        else                                             gap_cnt <= gap_cnt - 32'd1;
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign motion = (hold_cnt != 32'd0) & start;
    assign idle   = ~motion;

endmodule

// File: tb/tb_mouse_motion_tracker.sv
// Scoreboard bench for mouse_motion_tracker: directed scenarios plus random packets checked
// against an arithmetic reference model; a monitor pops expectations on pkt_valid / pkt_err.
module tb_mouse_motion_tracker;
    localparam int W    = 640;
    localparam int H    = 480;
    localparam int CW   = 11;
    localparam int BINP = 100;
    localparam int HYS  = 30;
    localparam int HOLD = 20;
    localparam int TO   = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [CW-1:0] pos_x, pos_y, bin_x, bin_y;
    logic          btn_left, btn_right, btn_middle, pkt_valid, pkt_err, motion, idle;

    mouse_motion_tracker #(
        .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .BIN(BINP), .HYSTERESIS(HYS),
        .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .pos_x(pos_x), .pos_y(pos_y), .bin_x(bin_x), .bin_y(bin_y),
        .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
        .pkt_valid(pkt_valid), .pkt_err(pkt_err), .motion(motion), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       px, py, bx, by;
        logic [2:0] btn;
        bit       chg;
    } exp_t;

    exp_t q[$];
    int   err_pending = 0;
    int   tests = 0, fails = 0;
    int   cyc = 0, last_chg = -1000000;
    int   mx, my, mbx, mby;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int next_bin(input int p, input int b);
        if (p >= (b + 1) * BINP + HYS || p + HYS < b * BINP) return p / BINP;
        return b;
    endfunction

    task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             output exp_t e);
        int dx, dy, nbx, nby;
        dx = b0[6] ? 0 : int'(b1) - (b0[4] ? 256 : 0);
        dy = b0[7] ? 0 : int'(b2) - (b0[5] ? 256 : 0);
        if (start) begin
            mx = clampi(mx + dx, 0, W - 1);
            my = clampi(my - dy, 0, H - 1);
        end
        nbx   = next_bin(mx, mbx);
        nby   = next_bin(my, mby);
        e.chg = (nbx != mbx) || (nby != mby);
        mbx   = nbx;
        mby   = nby;
        e.px  = mx;
        e.py  = my;
        e.bx  = mbx;
        e.by  = mby;
        e.btn = b0[2:0];
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int gap);
        exp_t e;
        model_pkt(b0, b1, b2, e);
        q.push_back(e);
        send_byte(b0);
        repeat (gap) idle_cycle();
        send_byte(b1);
        repeat (gap) idle_cycle();
        send_byte(b2);
    endtask

    task automatic send_bad(input logic [7:0] b);
        err_pending++;
        send_byte(b & 8'hF7);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        idle_cycle();
        idle_cycle();
        reset       = 1'b0;
        mx          = W / 2;
        my          = H / 2;
        mbx         = (W / 2) / BINP;
        mby         = (H / 2) / BINP;
        last_chg    = -1000000;
        err_pending = 0;
        q.delete();
    endtask

    // Monitor: pos/buttons on the pkt_valid cycle, bins/motion one cycle later
    initial begin : monitor
        exp_t cur, pend;
        bit   pend_v;
        int   exp_m;
        pend_v = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_v = 0;
                continue;
            end
            if (pend_v) begin
                pend_v = 0;
                if (pend.chg) last_chg = cyc;
                exp_m = (start && (cyc - last_chg < HOLD)) ? 1 : 0;
                chk("bin_x", int'(bin_x), pend.bx);
                chk("bin_y", int'(bin_y), pend.by);
                chk("motion", int'(motion), exp_m);
                chk("idle", int'(idle), 1 - exp_m);
            end
            if (pkt_err) begin
                chk("pkt_err_expected", (err_pending > 0) ? 1 : 0, 1);
                if (err_pending > 0) err_pending--;
            end
            if (pkt_valid) begin
                chk("pkt_valid_expected", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    chk("pos_x", int'(pos_x), cur.px);
                    chk("pos_y", int'(pos_y), cur.py);
                    chk("buttons", int'({btn_middle, btn_right, btn_left}), int'(cur.btn));
                    pend   = cur;
                    pend_v = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int hi, waited, px_before;
        logic [7:0] b0;
        do_reset();

        chk("rst_pos_x", int'(pos_x), 320);
        chk("rst_pos_y", int'(pos_y), 240);
        chk("rst_bin_x", int'(bin_x), 3);
        chk("rst_bin_y", int'(bin_y), 2);
        chk("rst_buttons", int'({btn_middle, btn_right, btn_left}), 0);
        chk("rst_pkt_valid", int'(pkt_valid), 0);
        chk("rst_pkt_err", int'(pkt_err), 0);
        chk("rst_motion", int'(motion), 0);
        chk("rst_idle", int'(idle), 1);

        send_packet(8'h08, 8'h0A, 8'h00, 0);
        repeat (3) idle_cycle();
        chk("t1_pos_x", int'(pos_x), 330);
        chk("t1_bin_x", int'(bin_x), 3);
        chk("t1_motion", int'(motion), 0);

        do_reset();
        send_packet(8'h08, 8'h64, 8'h00, 1);
        repeat (3) idle_cycle();
        chk("t2_pos_x_420", int'(pos_x), 420);
        chk("t2_bin_x_3", int'(bin_x), 3);
        send_packet(8'h08, 8'h0A, 8'h00, 0);
        waited = 0;
        while (!motion && waited < 10) begin idle_cycle(); waited++; end
        hi = 0;
        while (motion && hi < HOLD + 10) begin hi++; idle_cycle(); end
        chk("t2_bin_x_4", int'(bin_x), 4);
        chk("t2_hold_len", hi, HOLD);
        chk("t2_idle_after", int'(idle), 1);

        repeat (3) send_packet(8'h18, 8'h00, 8'h00, 0);
        repeat (3) send_packet(8'h08, 8'h00, 8'h7F, 0);
        repeat (3) idle_cycle();
        chk("t3_pos_x_clamp0", int'(pos_x), 0);
        chk("t3_bin_x_0", int'(bin_x), 0);
        chk("t3_pos_y_clamp0", int'(pos_y), 0);

        send_bad(8'h00);
        send_packet(8'h09, 8'h00, 8'h00, 0);
        repeat (3) idle_cycle();
        chk("t4_btn_left", int'(btn_left), 1);

        px_before = int'(pos_x);
        send_packet(8'h48, 8'hFF, 8'h00, 0);
        repeat (3) idle_cycle();
        chk("t5_overflow_x", int'(pos_x), px_before);
        start = 1'b0;
        send_packet(8'h0F, 8'h10, 8'h10, 0);
        repeat (3) idle_cycle();
        chk("t5_frozen_x", int'(pos_x), px_before);
        chk("t5_btns_upd", int'({btn_middle, btn_right, btn_left}), 7);
        chk("t5_motion_off", int'(motion), 0);
        start = 1'b1;

        send_packet(8'h08, 8'hFF, 8'h00, 0);
        send_byte(8'h09);
        send_byte(8'h0A);
        reset = 1'b1;
        idle_cycle();
        chk("t6_midrst_pos_x", int'(pos_x), 320);
        chk("t6_midrst_btn", int'(btn_left), 0);
        chk("t6_midrst_bin_x", int'(bin_x), 3);
        do_reset();
        send_packet(8'h08, 8'h0A, 8'h00, 0);
        repeat (3) idle_cycle();
        chk("t6_after_rst_x", int'(pos_x), 330);

`ifdef MOUSE_TIMEOUT_EN
        do_reset();
        send_byte(8'h08);
        send_byte(8'h05);
        err_pending++;
        repeat (TO + 3) idle_cycle();
        chk("t7_timeout_err", err_pending, 0);
        send_packet(8'h08, 8'h05, 8'h00, 0);
        repeat (3) idle_cycle();
        chk("t7_pos_x", int'(pos_x), 325);
`endif

        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) send_bad(8'($urandom));
            b0 = 8'($urandom) | 8'h08;
            send_packet(b0, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
            repeat ($urandom_range(1, 3)) idle_cycle();
        end

        repeat (5) idle_cycle();
        chk("scoreboard_drained", q.size(), 0);
        chk("errors_drained", err_pending, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
